uart_transmitter: RTL and testbench
===================================

// Module: uart_transmitter
// PURPOSE
//   8N1 UART serialiser; the upstream stage that drives the serial line read by uart_receiver.
//   Accepts a byte over a valid/ready handshake and shifts it out LSB-first on TxD:
//   1 start bit (0), 8 data bits, 1 stop bit (1).
//   Bit timing is derived from the same CLK_FREQ/BAUD_RATE scheme as the receiver, so TxD->RxD loopback works directly.
// PARAMETERS
//   CLK_FREQ   100_000_000  system clock frequency, Hz
//   BAUD_RATE  9600         line rate, bits/s
//   BIT_DIV    CLK_FREQ/BAUD_RATE (derived localparam, 10416 at defaults); clocks per bit; must be >= 2
// PORTS
//   clk_fpga   in   1  system clock, all logic on rising edge
//   reset_n    in   1  asynchronous active-low reset
//   tx_data    in   8  byte to send; sampled only on handshake
//   tx_valid   in   1  upstream has a byte on tx_data
//   tx_ready   out  1  block can accept a byte this cycle (high only in IDLE)
//   TxD        out  1  serial line, idle high
//   tx_busy    out  1  high from the cycle after acceptance to the end of the stop bit
//   tx_done    out  1  one-cycle pulse on the last cycle of the stop bit
// BEHAVIOUR
//   Reset (async assert, sync release):
//     state=IDLE, TxD=1, tx_ready=1, tx_busy=0, tx_done=0, bit counter=0, baud counter=0, shift reg=0.
//     Reset mid-frame aborts the frame; TxD returns to 1 immediately; the partial frame is not resumed.
//   Handshake: byte accepted on a rising edge with tx_valid&&tx_ready.
//     tx_data is latched into an 8-bit shift register on that edge; later tx_data changes are ignored.
//     tx_valid while busy is ignored (not queued); upstream holds it until tx_ready.
//   All outputs are registered. TxD drives the start bit (0) on the cycle after acceptance.
//   Baud counter: 0..BIT_DIV-1, reset to 0 on entry to each bit.
//     Every bit (start, D0..D7, stop) is held exactly BIT_DIV cycles.
//   FSM:
//     IDLE : TxD=1, tx_ready=1; on handshake -> START.
//     START: TxD=0 for BIT_DIV cycles -> DATA, bit counter=0.
//     DATA : TxD=shift[0]; at end of bit, shift right and bit counter+1;
//            after bit counter==7 completes -> STOP.
//     STOP : TxD=1 for BIT_DIV cycles; tx_done=1 on its final cycle -> IDLE.
//   Frame length acceptance->IDLE = 10*BIT_DIV cycles.
//   Back-to-back: a new byte is accepted in the first IDLE cycle, so the minimum inter-frame gap is
//     one extra clock of idle-high (stop bit effectively BIT_DIV+1 cycles); no line glitch.
//   tx_ready=0 in every state except IDLE; tx_busy = (state!=IDLE).
//   Default/illegal state -> IDLE with TxD=1.
// TESTING (sim with CLK_FREQ=64, BAUD_RATE=1 -> BIT_DIV=64)
//   1 Reset: hold reset_n=0, toggle clk -> TxD=1, tx_ready=1, tx_busy=0, tx_done=0.
//     Assert reset_n=0 asynchronously mid-cycle -> outputs reach reset values before the next edge.
//   2 Send 0xA5 -> TxD = 0,1,0,1,0,0,1,0,1,1, each level exactly 64 cycles.
//     Start bit begins 1 cycle after the handshake; tx_done pulses once, at cycle 640 after acceptance.
//   3 Data hold: accept 0x3C, then change tx_data to 0xFF on the next cycle -> line still carries 0x3C.
//     tx_valid held high during the frame -> no second acceptance until tx_ready.
//   4 Back-to-back: tx_valid held high with 0x00 then 0xFF.
//     -> Two frames separated by exactly one extra idle-high cycle; no glitch low on TxD.
//   5 Reset mid-frame: reset_n low during D3 of 0x55 -> TxD=1 at once.
//     After release, a new 0x81 sends cleanly from its start bit.
//   6 Loopback: TxD->RxD of uart_receiver (same CLK_FREQ/BAUD_RATE).
//     Bytes 0x00, 0xFF, 0xA5, 0x5A each read back on RxData after that frame's tx_done.

Source files
------------

// File: rtl/uart_transmitter.sv
// 8N1 UART transmitter: accepts a byte over valid/ready and shifts it out LSB-first on TxD.
// Every bit is held CLK_FREQ/BAUD_RATE clocks; all outputs are registered.
module uart_transmitter #(
  parameter int unsigned CLK_FREQ  = 100_000_000,
  parameter int unsigned BAUD_RATE = 9600
) (
  input  logic       clk_fpga,
  input  logic       reset_n,
  input  logic [7:0] tx_data,
  input  logic       tx_valid,
  output logic       tx_ready,
  output logic       TxD,
  output logic       tx_busy,
  output logic       tx_done
);

  localparam int unsigned BIT_DIV = CLK_FREQ / BAUD_RATE;
  localparam int unsigned CNT_W   = (BIT_DIV > 2) ? $clog2(BIT_DIV) : 1;
  localparam logic [CNT_W-1:0] BAUD_LAST = CNT_W'(BIT_DIV - 1);
  localparam logic [CNT_W-1:0] BAUD_PRE  = CNT_W'(BIT_DIV - 2);

  localparam logic [1:0] StIdle  = 2'd0;
  localparam logic [1:0] StStart = 2'd1;
  localparam logic [1:0] StData  = 2'd2;
  localparam logic [1:0] StStop  = 2'd3;

  logic [1:0]       state_q, state_d;
  logic [CNT_W-1:0] baud_q, baud_d;
  logic [2:0]       bit_q, bit_d;
  logic [7:0]       shift_q, shift_d;
  logic             txd_d, done_d, ready_d, busy_d;
  logic             end_bit;

  assign end_bit = (baud_q == BAUD_LAST);

  always_comb begin
    state_d = state_q;
    baud_d  = end_bit ? '0 : baud_q + 1'b1;
    bit_d   = bit_q;
    shift_d = shift_q;
    txd_d   = TxD;
    done_d  = 1'b0;
    unique case (state_q)
      StIdle: begin
        baud_d = '0;
        txd_d  = 1'b1;
        if (tx_valid && tx_ready) begin
          shift_d = tx_data;
          state_d = StStart;
          txd_d   = 1'b0;
        end
      end
      StStart: begin
        if (end_bit) begin
          state_d = StData;
          bit_d   = 3'd0;
          txd_d   = shift_q[0];
        end
      end
      StData: begin
        if (end_bit) begin
          shift_d = {1'b0, shift_q[7:1]};
          bit_d   = bit_q + 3'd1;
          if (bit_q == 3'd7) begin
            state_d = StStop;
            txd_d   = 1'b1;
          end else begin
            // Next data bit is the one about to shift into position 0.
            txd_d = shift_q[1];
          end
        end
      end
      StStop: begin
        // Registered pulse: set one cycle early so it is visible on the final stop cycle.
        done_d = (baud_q == BAUD_PRE);
        if (end_bit) begin
          state_d = StIdle;
        end
      end
      default: begin
        state_d = StIdle;
        baud_d  = '0;
        bit_d   = 3'd0;
        txd_d   = 1'b1;
      end
    endcase
    ready_d = (state_d == StIdle);
    busy_d  = (state_d != StIdle);
  end

  always_ff @(posedge clk_fpga or negedge reset_n) begin
    if (!reset_n) begin
      state_q  <= StIdle;
      baud_q   <= '0;
      bit_q    <= 3'd0;
      shift_q  <= 8'd0;
      TxD      <= 1'b1;
      tx_ready <= 1'b1;
      tx_busy  <= 1'b0;
      tx_done  <= 1'b0;
    end else begin
      state_q  <= state_d;
      baud_q   <= baud_d;
      bit_q    <= bit_d;
      shift_q  <= shift_d;
      TxD      <= txd_d;
      tx_ready <= ready_d;
      tx_busy  <= busy_d;
      tx_done  <= done_d;
    end
  end

endmodule

// File: tb/tb_uart_transmitter.sv
// Directed bench for uart_transmitter at BIT_DIV=64: frame shape, data hold, back-to-back,
// mid-frame reset, and a mid-bit sampling receiver model for loopback.
module tb_uart_transmitter;

  localparam int unsigned BIT_DIV = 64;
  localparam int unsigned FRAME   = 10 * BIT_DIV;

  logic       clk_fpga;
  logic       reset_n;
  logic [7:0] tx_data;
  logic       tx_valid;
  logic       tx_ready;
  logic       TxD;
  logic       tx_busy;
  logic       tx_done;

  int n_checks;
  int n_errors;

  uart_transmitter #(
    .CLK_FREQ (64),
    .BAUD_RATE(1)
  ) dut (
    .clk_fpga(clk_fpga),
    .reset_n (reset_n),
    .tx_data (tx_data),
    .tx_valid(tx_valid),
    .tx_ready(tx_ready),
    .TxD     (TxD),
    .tx_busy (tx_busy),
    .tx_done (tx_done)
  );

  initial clk_fpga = 1'b0;
  always #5 clk_fpga = ~clk_fpga;

  // Frame pattern: bit i is the line level during bit slot i (slot 0 = start, slot 9 = stop).
  typedef struct {
    logic [7:0] data;
    logic [9:0] pat;
    logic       hold_valid;
    logic [7:0] late_data;
  } vec_t;

  vec_t vecs[4];

  task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h, expected %0h", nm, act, exp);
    end
  endtask

  // Call just after a negedge; returns right after the accepting posedge.
  task automatic accept(input logic [7:0] d);
    logic ok;
    ok = 1'b0;
    tx_data  = d;
    tx_valid = 1'b1;
    for (int i = 0; i < 2000; i++) begin
      if (tx_ready === 1'b1) begin
        ok = 1'b1;
        break;
      end
      @(negedge clk_fpga);
    end
    check($sformatf("accept %02h ready seen", d), {31'd0, ok}, 32'd1);
    if (ok) @(posedge clk_fpga);
  endtask

  // Monitors cycles 1..FRAME after acceptance, then the first idle cycle.
  task automatic run_frame(input logic [7:0] data, input logic [9:0] pat, input logic hold_valid,
                           input logic [7:0] late_data);
    logic [9:0] bit_err;
    logic [7:0] rx;
    logic       done_err, busy_err, ready_err;
    int         b;
    bit_err   = '0;
    rx        = '0;
    done_err  = 1'b0;
    busy_err  = 1'b0;
    ready_err = 1'b0;
    for (int k = 1; k <= int'(FRAME); k++) begin
      @(negedge clk_fpga);
      if (k == 1) begin
        tx_valid = hold_valid;
        tx_data  = late_data;
      end
      b = (k - 1) / BIT_DIV;
      if (TxD !== pat[b]) bit_err[b] = 1'b1;
      if (((k - 1) % BIT_DIV) == BIT_DIV / 2 && b >= 1 && b <= 8) rx[b-1] = TxD;
      if (tx_done !== (k == int'(FRAME))) done_err = 1'b1;
      if (tx_busy !== 1'b1) busy_err = 1'b1;
      if (tx_ready !== 1'b0) ready_err = 1'b1;
    end
    for (int i = 0; i < 10; i++) begin
      check($sformatf("frame %02h slot %0d level-error flag", data, i), {31'd0, bit_err[i]}, 32'd0);
    end
    check($sformatf("frame %02h loopback byte", data), {24'd0, rx}, {24'd0, data});
    check($sformatf("frame %02h tx_done only at cycle 640", data), {31'd0, done_err}, 32'd0);
    check($sformatf("frame %02h tx_busy held", data), {31'd0, busy_err}, 32'd0);
    check($sformatf("frame %02h tx_ready low", data), {31'd0, ready_err}, 32'd0);
    @(negedge clk_fpga);
    check($sformatf("frame %02h idle TxD", data), {31'd0, TxD}, 32'd1);
    check($sformatf("frame %02h idle tx_ready", data), {31'd0, tx_ready}, 32'd1);
    check($sformatf("frame %02h idle tx_busy", data), {31'd0, tx_busy}, 32'd0);
    check($sformatf("frame %02h idle tx_done", data), {31'd0, tx_done}, 32'd0);
  endtask

  initial begin
    n_checks = 0;
    n_errors = 0;
    reset_n  = 1'b0;
    tx_valid = 1'b0;
    tx_data  = 8'h00;

    vecs[0] = '{data: 8'hA5, pat: 10'b1101001010, hold_valid: 1'b0, late_data: 8'h00};
    vecs[1] = '{data: 8'h3C, pat: 10'b1001111000, hold_valid: 1'b1, late_data: 8'hFF};
    vecs[2] = '{data: 8'h5A, pat: 10'b1010110100, hold_valid: 1'b0, late_data: 8'hA5};
    vecs[3] = '{data: 8'hFF, pat: 10'b1111111110, hold_valid: 1'b0, late_data: 8'h00};

    repeat (3) @(negedge clk_fpga);
    check("reset TxD", {31'd0, TxD}, 32'd1);
    check("reset tx_ready", {31'd0, tx_ready}, 32'd1);
    check("reset tx_busy", {31'd0, tx_busy}, 32'd0);
    check("reset tx_done", {31'd0, tx_done}, 32'd0);
    reset_n = 1'b1;
    @(negedge clk_fpga);

    for (int i = 0; i < 4; i++) begin
      accept(vecs[i].data);
      run_frame(vecs[i].data, vecs[i].pat, vecs[i].hold_valid, vecs[i].late_data);
      tx_valid = 1'b0;
    end

    // Back-to-back with tx_valid held: 0x00 then 0xFF, one idle-high cycle between.
    accept(8'h00);
    run_frame(8'h00, 10'b1000000000, 1'b1, 8'h00);
    tx_data = 8'hFF;
    @(posedge clk_fpga);
    run_frame(8'hFF, 10'b1111111110, 1'b1, 8'hFF);
    tx_valid = 1'b0;

    // Reset in the middle of D3 of 0x55.
    accept(8'h55);
    for (int k = 1; k <= 4 * int'(BIT_DIV) + 10; k++) begin
      @(negedge clk_fpga);
      tx_valid = 1'b0;
    end
    check("0x55 D3 level before reset", {31'd0, TxD}, 32'd0);
    #2;
    reset_n = 1'b0;
    #1;
    check("async reset TxD", {31'd0, TxD}, 32'd1);
    check("async reset tx_ready", {31'd0, tx_ready}, 32'd1);
    check("async reset tx_busy", {31'd0, tx_busy}, 32'd0);
    repeat (3) @(negedge clk_fpga);
    reset_n = 1'b1;
    @(negedge clk_fpga);
    check("post-reset TxD idle", {31'd0, TxD}, 32'd1);
    accept(8'h81);
    run_frame(8'h81, 10'b1100000010, 1'b0, 8'h00);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
